// File: rtl/wire_mem_pkg.sv
// Shared constants and address-window helpers for the wire-module memory.
// The window-index function turns a bus address into a window number.
package wire_mem_pkg;

    localparam logic [15:0] DEF_BASE_ADDR = 16'he664;
    localparam logic [15:0] DEF_WINDOW    = 16'h0222;

    // Field positions inside the STATUS1 word and the clear-everything bit of STATUS0 writes.
    localparam int S1_COUNT_LSB  = 0;
    localparam int S1_IDX_LSB    = 4;
    localparam int S1_VALID_BIT  = 15;
    localparam int CLEAR_ALL_BIT = 15;

    // 15 channels plus two status windows at most.
    localparam int          MAX_WINDOWS = 17;
    localparam logic [4:0]  NO_WINDOW   = 5'h1f;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_CHAN,
        WIN_STATUS0,
        WIN_STATUS1
    } win_kind_e;

    function automatic logic [4:0] win_index(
        input logic [31:0] a,
        input logic [31:0] base,
        input logic [31:0] win,
        input int          nwin
    );
        logic [4:0] idx;
        idx = NO_WINDOW;
        for (int k = 0; k < MAX_WINDOWS; k++) begin
            if ((k < nwin) && (a >= base + 32'(k) * win) && (a < base + 32'(k + 1) * win)) begin
                idx = 5'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wire_cut_detector.sv
// One wire channel: registered ADC sample, debounce counter and sticky cut flag.
// rise is combinational and marks the edge on which the flag goes 0->1.
module wire_cut_detector #(
    parameter int VAL_WIDTH       = 7,
    parameter int CUT_THRESH      = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [VAL_WIDTH-1:0] val,
    input  logic                 clr,
    output logic [VAL_WIDTH-1:0] sample,
    output logic                 flag,
    output logic                 rise
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [VAL_WIDTH-1:0] sample_q;
    logic                 sample_vld_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                 flag_q, flag_d;
    logic                 is_low;
    logic                 set;

    // The valid bit keeps the zeroed post-reset sample from counting as a low reading.
    always_comb begin
        is_low  = sample_vld_q && (32'(sample_q) < 32'(CUT_THRESH));
        cnt_inc = '0;
        if (is_low) begin
            cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        end
        // Only the step onto CNT_MAX sets, so a cleared flag needs a full new run.
        set    = is_low && (cnt_inc == CNT_MAX) && (cnt_q != CNT_MAX);
        cnt_d  = clr ? '0 : cnt_inc;
        flag_d = set | (flag_q & ~clr);
        rise   = flag_d & ~flag_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            cnt_q        <= '0;
            flag_q       <= 1'b0;
        end else begin
            sample_q     <= val;
            sample_vld_q <= 1'b1;
            cnt_q        <= cnt_d;
            flag_q       <= flag_d;
        end
    end

    assign sample = sample_q;
    assign flag   = flag_q;

endmodule

// File: rtl/wire_bank_mem.sv
// Bus-mapped bank of wire-cut detectors with first-cut tracking, saturating
// cut count, status windows and write-1-to-clear of the cut flags.
module wire_bank_mem
    import wire_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 16,
    parameter int                    ADDR_WIDTH      = 16,
    parameter int                    NUM_WIRES       = 6,
    parameter int                    VAL_WIDTH       = 7,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = DEF_BASE_ADDR,
    parameter logic [ADDR_WIDTH-1:0] WINDOW          = DEF_WINDOW,
    parameter int                    CUT_THRESH      = 16,
    parameter int                    DEBOUNCE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_WIRES*VAL_WIDTH-1:0] wire_val,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          data,
    input  logic                           en,
    input  logic                           wren,
    output logic [DATA_WIDTH-1:0]          q,
    output logic                           cut_event
);

    logic [VAL_WIDTH-1:0]  sample_w [NUM_WIRES];
    logic [NUM_WIRES-1:0]  flag_w, rise_w, clr_w;
    logic [4:0]            win;
    win_kind_e             kind;
    logic                  wr_status0, clear_all;
    logic                  unused_data;

    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  cut_event_q, cut_event_d;
    logic [3:0]            count_q, count_d, idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [3:0]            low_idx, base_count, base_idx;
    logic                  base_valid, rise_any;
    logic [4:0]            pop, sum;

    assign win = win_index(32'(addr), 32'(BASE_ADDR), 32'(WINDOW), NUM_WIRES + 2);

    always_comb begin
        kind = WIN_NONE;
        if (win < 5'(NUM_WIRES)) begin
            kind = WIN_CHAN;
        end else if (win == 5'(NUM_WIRES)) begin
            kind = WIN_STATUS0;
        end else if (win == 5'(NUM_WIRES + 1)) begin
            kind = WIN_STATUS1;
        end
    end

    assign wr_status0  = en && wren && (kind == WIN_STATUS0);
    assign clr_w       = wr_status0 ? data[NUM_WIRES-1:0] : '0;
    assign clear_all   = wr_status0 && data[CLEAR_ALL_BIT];
    assign unused_data = ^data;

    generate
        for (genvar gi = 0; gi < NUM_WIRES; gi++) begin : g_det
            wire_cut_detector #(
                .VAL_WIDTH       (VAL_WIDTH),
                .CUT_THRESH      (CUT_THRESH),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_det (
                .clk    (clk),
                .reset  (reset),
                .val    (wire_val[gi*VAL_WIDTH +: VAL_WIDTH]),
                .clr    (clr_w[gi]),
                .sample (sample_w[gi]),
                .flag   (flag_w[gi]),
                .rise   (rise_w[gi])
            );
        end
    endgenerate

    // Reads see the flags and counters as they stood before this edge.
    always_comb begin
        q_d = q_q;
        if (en && !wren) begin
            case (kind)
                WIN_CHAN: begin
                    for (int k = 0; k < NUM_WIRES; k++) begin
                        if (win == 5'(k)) begin
                            q_d = DATA_WIDTH'(sample_w[k]);
                        end
                    end
                end
                WIN_STATUS0: q_d = DATA_WIDTH'(flag_w);
                WIN_STATUS1: begin
                    q_d                          = '0;
                    q_d[S1_COUNT_LSB +: 4]       = count_q;
                    q_d[S1_IDX_LSB +: 4]         = idx_q;
                    q_d[S1_VALID_BIT]            = valid_q;
                end
                default: ;
            endcase
        end
    end

    // Clear-all is applied first so that rises on the same edge are still recorded.
    always_comb begin
        rise_any = |rise_w;
        low_idx  = '0;
        pop      = '0;
        for (int k = NUM_WIRES - 1; k >= 0; k--) begin
            if (rise_w[k]) begin
                low_idx = 4'(k);
            end
        end
        for (int k = 0; k < NUM_WIRES; k++) begin
            pop = pop + 5'(rise_w[k]);
        end
        base_count = clear_all ? 4'd0 : count_q;
        base_idx   = clear_all ? 4'd0 : idx_q;
        base_valid = clear_all ? 1'b0 : valid_q;
        sum        = {1'b0, base_count} + pop;
        count_d    = (sum > 5'd15) ? 4'd15 : sum[3:0];
        valid_d    = base_valid;
        idx_d      = base_idx;
        if (!base_valid && rise_any) begin
            valid_d = 1'b1;
            idx_d   = low_idx;
        end
        cut_event_d = rise_any;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q         <= '0;
            cut_event_q <= 1'b0;
            count_q     <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            q_q         <= q_d;
            cut_event_q <= cut_event_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
        end
    end

    assign q         = q_q;
    assign cut_event = cut_event_q;

endmodule

// File: tb/tb_wire_bank_mem.sv
// Self-checking bench for wire_bank_mem: table of bus accesses plus
// hand-written debounce, set/clear and reset sequences.
module tb_wire_bank_mem;

    localparam int NW = 6;
    localparam int VW = 7;

    logic              clk;
    logic              reset;
    logic [NW*VW-1:0]  wire_val;
    logic [15:0]       addr;
    logic [15:0]       data;
    logic              en;
    logic              wren;
    logic [15:0]       q;
    logic              cut_event;

    wire_bank_mem dut (
        .clk       (clk),
        .reset     (reset),
        .wire_val  (wire_val),
        .addr      (addr),
        .data      (data),
        .en        (en),
        .wren      (wren),
        .q         (q),
        .cut_event (cut_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        en;
        logic        wren;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;

    sb_t  sb[$];
    vec_t vt[14];
    int   checks = 0;
    int   errors = 0;
    int   ev_cnt = 0;
    int   ev0;

    always @(negedge clk) if (cut_event === 1'b1) ev_cnt++;

    function automatic vec_t mk(logic [15:0] a, logic e, logic w, logic [15:0] d,
                                logic [15:0] x, string n);
        vec_t v;
        v.addr = a; v.en = e; v.wren = w; v.data = d; v.exp = x; v.name = n;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic pop_chk();
        sb_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(e.name, 32'(q), 32'(e.exp));
        end
    endtask

    task automatic bus(input logic [15:0] a, input logic e, input logic w,
                       input logic [15:0] d, input logic [15:0] x, input string n);
        sb_t s;
        addr = a; en = e; wren = w; data = d;
        s.exp = x; s.name = n;
        sb.push_back(s);
        tick();
        en = 1'b0; wren = 1'b0;
        pop_chk();
    endtask

    task automatic set_wire(input int i, input logic [6:0] v);
        wire_val[i*VW +: VW] = v;
    endtask

    localparam logic [15:0] S0 = 16'hf330;
    localparam logic [15:0] S1 = 16'hf552;

    logic [6:0] pat [1:9];

    initial begin
        reset = 1'b1; en = 1'b0; wren = 1'b0; addr = '0; data = '0;
        for (int i = 0; i < NW; i++) set_wire(i, 7'(100 + i));

        vt[0]  = mk(16'he664, 1, 0, 16'h0000, 16'd100, "ch0");
        vt[1]  = mk(16'he885, 1, 0, 16'h0000, 16'd100, "ch0_last_addr");
        vt[2]  = mk(16'he886, 1, 0, 16'h0000, 16'd101, "ch1_first_addr");
        vt[3]  = mk(16'heaa8, 1, 0, 16'h0000, 16'd102, "ch2");
        vt[4]  = mk(16'hecca, 1, 0, 16'h0000, 16'd103, "ch3");
        vt[5]  = mk(16'heeec, 1, 0, 16'h0000, 16'd104, "ch4");
        vt[6]  = mk(16'hf10e, 1, 0, 16'h0000, 16'd105, "ch5");
        vt[7]  = mk(16'he663, 1, 0, 16'h0000, 16'd105, "below_base_hold");
        vt[8]  = mk(S0,       1, 0, 16'h0000, 16'h0000, "status0_idle");
        vt[9]  = mk(16'hf553, 1, 0, 16'h0000, 16'h0000, "status1_idle");
        vt[10] = mk(16'hf774, 1, 0, 16'h0000, 16'h0000, "past_end_hold");
        vt[11] = mk(16'hf10e, 0, 0, 16'h0000, 16'h0000, "en_low_hold");
        vt[12] = mk(16'he664, 1, 1, 16'hffff, 16'h0000, "wr_chan_ignored");
        vt[13] = mk(16'he664, 1, 0, 16'h0000, 16'd100, "ch0_after_wr");

        // Reset state
        tick(); tick(); tick();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_evt", 32'(cut_event), 32'h0);
        reset = 1'b0;
        tick(); tick();

        for (int i = 0; i < 14; i++) begin
            bus(vt[i].addr, vt[i].en, vt[i].wren, vt[i].data, vt[i].exp, vt[i].name);
        end
        chk("p1_no_evt", 32'(ev_cnt), 32'd0);

        // Wire 3 cut: event exactly 4 edges after the first low sample
        set_wire(3, 7'd5);
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("p2_evt%0d", i), 32'(cut_event), 32'(i == 4));
        end
        tick();
        chk("p2_evt_off", 32'(cut_event), 32'h0);
        chk("p2_evt_count", 32'(ev_cnt), 32'd1);
        bus(S0, 1, 0, 16'h0, 16'h0008, "p2_status0");
        bus(S1, 1, 0, 16'h0, 16'h8031, "p2_status1");
        set_wire(3, 7'd103);
        tick();

        // Wire 2: 3-cycle glitch, then a 4-cycle run; read races the set
        pat[1] = 7'd5; pat[2] = 7'd5; pat[3] = 7'd5; pat[4] = 7'd102;
        pat[5] = 7'd5; pat[6] = 7'd5; pat[7] = 7'd5; pat[8] = 7'd5; pat[9] = 7'd5;
        for (int s = 1; s <= 8; s++) begin
            set_wire(2, pat[s]);
            tick();
            chk($sformatf("p3_evt%0d", s), 32'(cut_event), 32'h0);
        end
        set_wire(2, pat[9]);
        bus(S0, 1, 0, 16'h0, 16'h0008, "p3_read_during_set");
        chk("p3_evt9", 32'(cut_event), 32'h1);
        bus(S0, 1, 0, 16'h0, 16'h000c, "p3_status0");
        bus(S1, 1, 0, 16'h0, 16'h8032, "p3_status1");
        set_wire(2, 7'd102);
        tick(); tick();

        // Wires 1 and 4 together after a full clear
        bus(S0, 1, 1, 16'h803f, 16'h8032, "p4_clear_wr_hold");
        bus(S0, 1, 0, 16'h0, 16'h0000, "p4_status0_clr");
        bus(S1, 1, 0, 16'h0, 16'h0000, "p4_status1_clr");
        ev0 = ev_cnt;
        set_wire(1, 7'd5); set_wire(4, 7'd5);
        for (int i = 0; i < 6; i++) tick();
        chk("p4_single_evt", 32'(ev_cnt - ev0), 32'd1);
        bus(S0, 1, 0, 16'h0, 16'h0012, "p4_status0");
        bus(S1, 1, 0, 16'h0, 16'h8012, "p4_status1");
        set_wire(1, 7'd101); set_wire(4, 7'd104);
        tick(); tick();

        // Set wins over a same-edge clear; then a bit clear with the wire still low
        bus(S0, 1, 1, 16'h803f, 16'h8012, "p5_clear_wr_hold");
        bus(S1, 1, 0, 16'h0, 16'h0000, "p5_status1_clr");
        set_wire(3, 7'd5);
        for (int i = 0; i < 4; i++) tick();
        bus(S0, 1, 1, 16'h8008, 16'h0000, "p5_wr_setwins_hold");
        chk("p5_evt", 32'(cut_event), 32'h1);
        bus(S0, 1, 0, 16'h0, 16'h0008, "p5_set_wins");
        for (int i = 0; i < 5; i++) tick();
        bus(S0, 1, 1, 16'h0008, 16'h0008, "p5_wr_bitclr_hold");
        chk("p5_evt_cleared", 32'(cut_event), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("p5_reset_evt%0d", i), 32'(cut_event), 32'(i == 4));
        end
        set_wire(3, 7'd103);
        tick(); tick();
        bus(S0, 1, 1, 16'h8008, 16'h0008, "p5_wr_clrall_hold");
        bus(S0, 1, 0, 16'h0, 16'h0000, "p5_status0_after");
        bus(S1, 1, 0, 16'h0, 16'h0000, "p5_status1_after");

        // Reset two samples into a debounce run on wire 0
        set_wire(0, 7'd5);
        bus(16'he886, 1, 0, 16'h0, 16'd101, "p6_ch1");
        tick();
        reset = 1'b1;
        tick();
        chk("p6_rst_q", 32'(q), 32'h0);
        reset = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            tick();
            chk($sformatf("p6_evt%0d", i), 32'(cut_event), 32'(i == 4));
        end
        bus(S0, 1, 0, 16'h0, 16'h0001, "p6_status0");
        bus(S1, 1, 0, 16'h0, 16'h8001, "p6_status1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wire_bank_mem.md
# wire_bank_mem

Memory-mapped wire-module peripheral on the KTANE CPU data bus, generalised to NUM_WIRES channels. Each channel's ADC reading is registered, debounced against a cut threshold, and latched into sticky cut flags. The block records first-cut order and a saturating cut count, exposes raw values and status through address windows, and accepts write-1-to-clear writes. Sits beside the other module memories on the shared addr/data/en bus.

## Interface
- DATA_WIDTH, 16, bus data width (≥16)
- ADDR_WIDTH, 16, bus address width
- NUM_WIRES, 6, channel count, 1..15
- VAL_WIDTH, 7, ADC value width per channel (≤ DATA_WIDTH)
- BASE_ADDR, 16'he664, start of channel 0 window
- WINDOW, 16'h0222, size of every window
- CUT_THRESH, 16, value strictly below this counts as "cut"
- DEBOUNCE_CYCLES, 4, consecutive low samples needed to declare a cut (≥1)

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- wire_val  in  NUM_WIRES*VAL_WIDTH  packed ADC values, channel i at [i*VAL_WIDTH +: VAL_WIDTH]
- addr  in  ADDR_WIDTH  bus address
- data  in  DATA_WIDTH  bus write data
- en  in  1  bus access enable
- wren  in  1  write strobe, qualified by en
- q  out  DATA_WIDTH  registered read data
- cut_event  out  1  one-cycle pulse when any flag newly sets

## Operation
- Window k covers [BASE_ADDR + k*WINDOW, BASE_ADDR + (k+1)*WINDOW), half-open. Windows 0..NUM_WIRES-1: channel k; window NUM_WIRES: STATUS0; window NUM_WIRES+1: STATUS1.
- Read (en=1, wren=0): channel window → q = zero-extended registered sample; STATUS0 → q = cut mask in bits [NUM_WIRES-1:0], rest 0; STATUS1 → q[3:0] = cut_count, q[7:4] = first_idx, q[15] = first_valid, rest 0. Address outside all windows, or en=0: q holds.
- Write (en=1, wren=1): STATUS0 → flags with data bit=1 clear; and if data[15]=1, first_valid, first_idx and cut_count also clear. All other writes are ignored. q holds during writes.
- Per channel: sample register; debounce counter increments while sample < CUT_THRESH, saturating at DEBOUNCE_CYCLES; counter returns to 0 on any sample ≥ CUT_THRESH. The flag sets when the counter reaches DEBOUNCE_CYCLES and stays set (sticky) until cleared or reset.
- Cleared flag with wire still low: re-sets after DEBOUNCE_CYCLES more low samples, because clearing also zeroes that channel's counter.
- The first flag set while first_valid=0 loads first_idx and sets first_valid. If several flags set in the same cycle, the lowest index wins.
- cut_count: +1 per flag 0→1 transition, counting all simultaneous transitions (popcount), saturating at 15.
- Simultaneous set and clear on the same flag: set wins.

## Timing
- Reset values: q=0, cut_event=0, all samples/counters/flags=0, first_valid=0, first_idx=0, cut_count=0.
- Read latency is 1 cycle: q is valid on the edge after addr/en are sampled.
- Sample path: wire_val is registered at edge N. With DEBOUNCE_CYCLES=D and a constant low value from edge N, the flag is visible at edge N+D.
- cut_event is high during the cycle in which the flag first reads 1.
- A read in the same cycle a flag sets returns the pre-set value.
- Reset asserted mid-debounce discards all progress. The first low sample after reset restarts the count.

## Structure
- Shared package/include wire_mem_pkg: BASE_ADDR/WINDOW defaults, STATUS1 field positions, the CLEAR_ALL bit (15), and a window-index function.
- One sub-module, wire_cut_detector, instantiated NUM_WIRES times via generate. It holds the sample reg, debounce counter and sticky flag, with ports clk, reset, val, clr, sample, flag, rise.
- The top level holds address decode, the first-cut/count logic and the q register.

## Test plan
- Reset, then read 16'he664..16'hf330 window starts with all wires at 7'd100 → channel reads return 100, STATUS0=0, STATUS1=0, cut_event never pulses.
- Wire 3 drops to 5 for 4 cycles → STATUS0=16'h0008, STATUS1=16'h8031 (valid, idx 3, count 1), one cut_event pulse exactly 4 edges after the first low sample.
- Wire 2 low for 3 cycles, high for 1, low for 4 → no flag after the 3-cycle glitch; flag set on the 4th cycle of the second run.
- Wires 1 and 4 cut in the same cycle → STATUS0=16'h0012, first_idx=1, count=2, single cut_event pulse.
- Write 16'h8008 to STATUS0 in the cycle wire 3's flag sets → flag remains set (set wins); a later write of 16'h8008 with wire 3 back high clears mask, count and first_valid.
- Assert reset mid-debounce (2 of 4 low samples) then release with wire still low → flag sets 4 cycles after release, not 2; q=0 on the cycle after reset.
